pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32IM pipeline. It takes register-address and control information from ID/EX, branch resolution from EX, busywait from both memories and the multi-cycle mul/div handshake. Each cycle it produces a per-boundary enable and flush for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It tracks multi-cycle mul/div occupancy with a small FSM and counts front-end stall cycles for performance analysis.

## Interface
- CNT_W, 16, width of the saturating stall-cycle counter
- CLK  in  1  pipeline clock; all state updates on posedge
- reset  in  1  reset reset, synchronous, active-high; clock CLK
- id_rs1_addr, id_rs2_addr  in  5 each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads that source
- ex_mem_read  in  1  instruction in EX is a load
- ex_write_addr  in  5  destination register of the instruction in EX
- branch_taken  in  1  EX resolved a taken branch/jump (redirect this cycle)
- muldiv_start  in  1  EX holds an M-extension op
- muldiv_done  in  1  mul/div result valid this cycle (may coincide with start)
- imem_busywait, dmem_busywait  in  1 each  memory not ready
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register captures its input at the next edge
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  register loads a bubble (all zeros) at the next edge; flush=1 always implies the matching en=1
- fsm_state  out  2  0=RUN, 1=MD_WAIT
- stall_cycles  out  CNT_W  count of cycles with pc_en=0

## Operation
- Outputs are combinational from the inputs and the registered state. Evaluate the priority list below top-down; the first match applies. Defaults are all en=1 and all flush=0.
- While reset=1, force all en=0 and all flush=0. At the edge, the state goes to RUN and stall_cycles goes to 0.
- P1, dmem_busywait=1:
  - pc/if_id/id_ex/ex_mem en=0.
  - mem_wb_flush=1 (bubble into WB).
  - The state is held, including MD_WAIT.
- P2, MD stall, active when (state=MD_WAIT or muldiv_start=1) and muldiv_done=0:
  - pc/if_id/id_ex en=0.
  - ex_mem_flush=1.
  - mem_wb_en=1.
  - RUN→MD_WAIT at the edge.
- MD_WAIT with muldiv_done=1 gives defaults and MD_WAIT→RUN. In MD_WAIT, muldiv_start is ignored as a new request.
- P3, branch_taken=1: if_id_flush=1 and id_ex_flush=1. Everything else uses defaults, so the PC captures the redirect target.
- P4, load-use: true when ex_mem_read=1, ex_write_addr≠0, and (id_uses_rs1 with id_rs1_addr=ex_write_addr, or id_uses_rs2 with id_rs2_addr=ex_write_addr).
  - pc_en=0, if_id_en=0.
  - id_ex_flush=1.
- P5, imem_busywait=1: pc_en=0 and if_id_flush=1. The back end runs.
- stall_cycles increments by 1 on every non-reset edge where pc_en=0 and saturates at all ones (no wrap).
- x0 is never a hazard source, and address comparison is exact on 5 bits.

## Timing
- Enables and flushes take effect at the same posedge the inputs are sampled. A busywait raised mid-cycle freezes the pipeline at the next edge, with no added latency.
- A load-use hazard costs exactly 1 bubble, provided the load completes in MEM without busywait.
- A taken branch costs 2 bubbles (IF/ID and ID/EX squashed).
- A mul/div taking N cycles (done asserted in cycle N of EX occupancy) inserts N−1 bubbles into EX/MEM. A single-cycle op (start and done together) inserts 0 bubbles and never enters MD_WAIT.
- dmem_busywait during MD_WAIT freezes everything. muldiv_done seen in that frozen window is not consumed: the state stays MD_WAIT. The mul/div unit must hold done until the first cycle with dmem_busywait=0.
- branch_taken together with imem_busywait: the branch wins and pc_en=1. The fetch is abandoned, and the imem must accept a new address.
- Load-use together with imem_busywait: load-use wins, and IF/ID holds rather than flushing.
- Reset asserted mid-MD_WAIT or mid-stall returns to RUN on the next edge; no pending state survives.

## Test plan
- Load-use: EX lw writes x5, ID add reads rs2=x5 with id_uses_rs2=1 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; the next cycle gives defaults and stall_cycles=1.
- Same as above with ex_write_addr=0, or id_uses_rs2=0 → no stall.
- Taken branch with imem_busywait=1 in the same cycle → if_id_flush=1, id_ex_flush=1, pc_en=1; stall_cycles unchanged.
- DIV with done in the 4th cycle → fsm_state=1 for 3 cycles with ex_mem_flush=1 and pc_en=0, then RUN; stall_cycles=3. A MUL with start and done together gives no stall.
- dmem_busywait for 3 cycles during MD_WAIT, with done held → all front en=0 and mem_wb_flush=1 for 3 cycles, fsm_state stays 1, then a clean exit.
- With CNT_W=4, hold imem_busywait for 20 cycles → stall_cycles saturates at 15. Asserting reset gives 0 and RUN one edge later.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32IM pipeline: per-boundary enables and
// flushes, mul/div occupancy tracking and a saturating front-end stall counter.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_write_addr,
  input  logic             branch_taken,
  input  logic             muldiv_start,
  input  logic             muldiv_done,
  input  logic             imem_busywait,
  input  logic             dmem_busywait,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       fsm_state,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             loadUse;

  // x0 never creates a dependency, so a load targeting it is harmless.
  assign loadUse = ex_mem_read && (ex_write_addr != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1_addr == ex_write_addr)) ||
                    (id_uses_rs2 && (id_rs2_addr == ex_write_addr)));

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    state_d      = state_q;

    if (reset) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      state_d   = RUN;
    end else if (dmem_busywait) begin
      // Frozen window: a done seen here is not consumed, MD_WAIT persists.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (((state_q == MD_WAIT) || muldiv_start) && !muldiv_done) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
      state_d      = MD_WAIT;
    end else if (state_q == MD_WAIT) begin
      state_d = RUN;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (loadUse) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (imem_busywait) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_en && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= RUN;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign fsm_state    = state_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl; the DUT counter is built 4 bits
// wide so saturation is reachable quickly.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1_addr, id_rs2_addr, ex_write_addr;
  logic             id_uses_rs1, id_uses_rs2, ex_mem_read;
  logic             branch_taken, muldiv_start, muldiv_done;
  logic             imem_busywait, dmem_busywait;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0]       fsm_state;
  logic [CNT_W-1:0] stall_cycles;
  logic [8:0]       ctl;

  int vectors    = 0;
  int miscompares = 0;

  // Packed view: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem,mem_wb flushes}
  localparam logic [8:0] CTL_DEF    = 9'b11111_0000;
  localparam logic [8:0] CTL_RST    = 9'b00000_0000;
  localparam logic [8:0] CTL_LU     = 9'b00111_0100;
  localparam logic [8:0] CTL_BR     = 9'b11111_1100;
  localparam logic [8:0] CTL_IMEM   = 9'b01111_1000;
  localparam logic [8:0] CTL_MD     = 9'b00011_0010;
  localparam logic [8:0] CTL_DMEM   = 9'b00001_0001;

  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_write_addr(ex_write_addr),
    .branch_taken(branch_taken), .muldiv_start(muldiv_start), .muldiv_done(muldiv_done),
    .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .fsm_state(fsm_state), .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic setIdle;
    id_rs1_addr   = 5'd0;
    id_rs2_addr   = 5'd0;
    ex_write_addr = 5'd0;
    id_uses_rs1   = 1'b0;
    id_uses_rs2   = 1'b0;
    ex_mem_read   = 1'b0;
    branch_taken  = 1'b0;
    muldiv_start  = 1'b0;
    muldiv_done   = 1'b0;
    imem_busywait = 1'b0;
    dmem_busywait = 1'b0;
  endtask

  task automatic doReset;
    setIdle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    setIdle();
    reset = 1'b1;
    #1;
    vectors++;
    if (ctl !== CTL_RST) begin
      miscompares++;
      $display("[TB] FAIL reset_ctl got %b expected %b", ctl, CTL_RST);
    end
    tick();
    vectors++;
    if (fsm_state !== 2'd0 || stall_cycles !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state got fsm=%0d cnt=%0d expected fsm=0 cnt=0", fsm_state, stall_cycles);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (ctl !== CTL_DEF) begin
      miscompares++;
      $display("[TB] FAIL idle_ctl got %b expected %b", ctl, CTL_DEF);
    end
  endtask

  task automatic test_load_use;
    doReset();
    ex_mem_read = 1'b1; ex_write_addr = 5'd5;
    id_rs1_addr = 5'd3; id_uses_rs1 = 1'b1;
    id_rs2_addr = 5'd5; id_uses_rs2 = 1'b1;
    #1;
    vectors++;
    if (ctl !== CTL_LU) begin
      miscompares++;
      $display("[TB] FAIL load_use_rs2 got %b expected %b", ctl, CTL_LU);
    end
    tick();
    setIdle();
    #1;
    vectors++;
    if (ctl !== CTL_DEF || stall_cycles !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL load_use_after got ctl=%b cnt=%0d expected ctl=%b cnt=1", ctl, stall_cycles, CTL_DEF);
    end
    ex_mem_read = 1'b1; ex_write_addr = 5'd31;
    id_rs1_addr = 5'd31; id_uses_rs1 = 1'b1;
    #1;
    vectors++;
    if (ctl !== CTL_LU) begin
      miscompares++;
      $display("[TB] FAIL load_use_rs1 got %b expected %b", ctl, CTL_LU);
    end
  endtask

  task automatic test_no_hazard;
    doReset();
    ex_mem_read = 1'b1; ex_write_addr = 5'd0;
    id_rs2_addr = 5'd0; id_uses_rs2 = 1'b1;
    #1;
    vectors++;
    if (ctl !== CTL_DEF) begin
      miscompares++;
      $display("[TB] FAIL x0_no_hazard got %b expected %b", ctl, CTL_DEF);
    end
    ex_write_addr = 5'd5; id_rs2_addr = 5'd5; id_uses_rs2 = 1'b0;
    #1;
    vectors++;
    if (ctl !== CTL_DEF) begin
      miscompares++;
      $display("[TB] FAIL unused_rs2 got %b expected %b", ctl, CTL_DEF);
    end
    id_uses_rs2 = 1'b1; id_rs2_addr = 5'd21;
    #1;
    vectors++;
    if (ctl !== CTL_DEF) begin
      miscompares++;
      $display("[TB] FAIL addr_diff got %b expected %b", ctl, CTL_DEF);
    end
    id_rs2_addr = 5'd5; ex_mem_read = 1'b0;
    #1;
    vectors++;
    if (ctl !== CTL_DEF) begin
      miscompares++;
      $display("[TB] FAIL not_load got %b expected %b", ctl, CTL_DEF);
    end
  endtask

  task automatic test_branch_imem;
    doReset();
    branch_taken = 1'b1; imem_busywait = 1'b1;
    #1;
    vectors++;
    if (ctl !== CTL_BR) begin
      miscompares++;
      $display("[TB] FAIL branch_imem got %b expected %b", ctl, CTL_BR);
    end
    tick();
    branch_taken = 1'b0;
    #1;
    vectors++;
    if (stall_cycles !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL branch_cnt got %0d expected 0", stall_cycles);
    end
    vectors++;
    if (ctl !== CTL_IMEM) begin
      miscompares++;
      $display("[TB] FAIL imem_only got %b expected %b", ctl, CTL_IMEM);
    end
    ex_mem_read = 1'b1; ex_write_addr = 5'd7;
    id_rs1_addr = 5'd7; id_uses_rs1 = 1'b1;
    #1;
    vectors++;
    if (ctl !== CTL_LU) begin
      miscompares++;
      $display("[TB] FAIL lu_over_imem got %b expected %b", ctl, CTL_LU);
    end
    tick();
    setIdle();
    #1;
    vectors++;
    if (stall_cycles !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL imem_cnt got %0d expected 1", stall_cycles);
    end
  endtask

  task automatic test_muldiv;
    logic [1:0] expFsm [4] = '{2'd0, 2'd1, 2'd1, 2'd1};
    logic [8:0] expCtl [4] = '{CTL_MD, CTL_MD, CTL_MD, CTL_DEF};
    doReset();
    muldiv_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      muldiv_done = (i == 3);
      #1;
      vectors++;
      if (ctl !== expCtl[i] || fsm_state !== expFsm[i]) begin
        miscompares++;
        $display("[TB] FAIL div_cycle%0d got ctl=%b fsm=%0d expected ctl=%b fsm=%0d",
                 i + 1, ctl, fsm_state, expCtl[i], expFsm[i]);
      end
      tick();
    end
    muldiv_start = 1'b0; muldiv_done = 1'b0;
    #1;
    vectors++;
    if (fsm_state !== 2'd0 || stall_cycles !== 4'd3) begin
      miscompares++;
      $display("[TB] FAIL div_exit got fsm=%0d cnt=%0d expected fsm=0 cnt=3", fsm_state, stall_cycles);
    end
    muldiv_start = 1'b1; muldiv_done = 1'b1;
    #1;
    vectors++;
    if (ctl !== CTL_DEF) begin
      miscompares++;
      $display("[TB] FAIL mul_1cyc got %b expected %b", ctl, CTL_DEF);
    end
    tick();
    setIdle();
    #1;
    vectors++;
    if (fsm_state !== 2'd0 || stall_cycles !== 4'd3) begin
      miscompares++;
      $display("[TB] FAIL mul_after got fsm=%0d cnt=%0d expected fsm=0 cnt=3", fsm_state, stall_cycles);
    end
  endtask

  task automatic test_dmem_in_mdwait;
    doReset();
    muldiv_start = 1'b1;
    tick();
    dmem_busywait = 1'b1; muldiv_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (ctl !== CTL_DMEM || fsm_state !== 2'd1) begin
        miscompares++;
        $display("[TB] FAIL dmem_freeze%0d got ctl=%b fsm=%0d expected ctl=%b fsm=1",
                 i, ctl, fsm_state, CTL_DMEM);
      end
      tick();
    end
    dmem_busywait = 1'b0;
    #1;
    vectors++;
    if (ctl !== CTL_DEF || fsm_state !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL md_release got ctl=%b fsm=%0d expected ctl=%b fsm=1", ctl, fsm_state, CTL_DEF);
    end
    tick();
    setIdle();
    #1;
    vectors++;
    if (fsm_state !== 2'd0 || stall_cycles !== 4'd4) begin
      miscompares++;
      $display("[TB] FAIL md_clean_exit got fsm=%0d cnt=%0d expected fsm=0 cnt=4", fsm_state, stall_cycles);
    end
    muldiv_start = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    setIdle();
    #1;
    vectors++;
    if (fsm_state !== 2'd0 || stall_cycles !== 4'd0 || ctl !== CTL_DEF) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_md got fsm=%0d cnt=%0d ctl=%b expected fsm=0 cnt=0 ctl=%b",
               fsm_state, stall_cycles, ctl, CTL_DEF);
    end
  endtask

  task automatic test_saturation;
    doReset();
    imem_busywait = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) begin
        vectors++;
        if (stall_cycles !== 4'd15) begin
          miscompares++;
          $display("[TB] FAIL sat_reach got %0d expected 15", stall_cycles);
        end
      end
    end
    vectors++;
    if (stall_cycles !== 4'd15) begin
      miscompares++;
      $display("[TB] FAIL sat_hold got %0d expected 15", stall_cycles);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    setIdle();
    #1;
    vectors++;
    if (stall_cycles !== 4'd0 || fsm_state !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL sat_reset got cnt=%0d fsm=%0d expected cnt=0 fsm=0", stall_cycles, fsm_state);
    end
  endtask

  // Scenarios run back to back; each one starts from its own reset.
  initial begin
    reset = 1'b1;
    setIdle();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_imem();
    test_muldiv();
    test_dmem_in_mdwait();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
